// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types, constants and helpers for the UART blocks.
// Revision    : 1.0 - initial release
// ============================================================================

package uart_pkg;

  // Number of data bits per 8N1 frame.
  localparam int UART_DATA_BITS = 8;

  // Receiver state encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  // Whole clocks per bit period; the remainder is dropped on purpose, so
  // the sampling point drifts by at most one clock per bit.
  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_sync_fifo
// Description : Single-clock FIFO with a push/full write side and a
//               valid/ready read side. No same-cycle bypass: a push into an
//               empty FIFO becomes visible on the following cycle.
// Revision    : 1.0 - initial release
// ============================================================================

module uart_sync_fifo #(
  parameter int Width = 8,
  parameter int Depth = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [Width-1:0]         push_data,
  output logic                     full,
  output logic                     pop_valid,
  input  logic                     pop_ready,
  output logic [Width-1:0]         pop_data,
  output logic [$clog2(Depth):0]   level
);

  localparam int                  c_addr_w = $clog2(Depth);
  localparam logic [c_addr_w:0]   c_depth  = (c_addr_w + 1)'(Depth);
  localparam logic [c_addr_w:0]   c_one    = (c_addr_w + 1)'(1);
  localparam logic [c_addr_w-1:0] c_step   = c_addr_w'(1);

  logic [Width-1:0]    r_mem [Depth];
  logic [c_addr_w-1:0] r_wr_ptr;
  logic [c_addr_w-1:0] r_rd_ptr;
  logic [c_addr_w:0]   r_level;

  logic w_empty;
  logic w_do_pop;
  logic w_do_push;

  assign w_empty   = (r_level == '0);
  assign full      = (r_level == c_depth);
  assign w_do_pop  = pop_ready & ~w_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_push = push & (~full | w_do_pop);

  assign pop_valid = ~w_empty;
  // Head byte is forced to zero while empty so the output is clean after reset.
  assign pop_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign level     = r_level;

  // Storage array: written only on an accepted push, never reset.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + c_step;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + c_step;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + c_one;
        2'b01:   r_level <= r_level - c_one;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule : uart_sync_fifo

`default_nettype wire

// File: rtl/uart_rx_sink.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sink
// Description : 8N1 UART receiver feeding a small byte FIFO. Holds the input
//               synchronizer, the frame FSM with its counters, and the sticky
//               overflow flag; storage lives in uart_sync_fifo.
// Revision    : 1.0 - initial release
// ============================================================================

module uart_rx_sink
  import uart_pkg::*;
#(
  parameter int ClockFrequency = 50_000_000,
  parameter int BaudRate       = 115_200,
  parameter int FifoDepth      = 8
) (
  input  logic                         clk_sys_i,
  input  logic                         rst_sys_i,
  input  logic                         uart_rx_i,
  output logic [UART_DATA_BITS-1:0]    rx_data_o,
  output logic                         rx_valid_o,
  input  logic                         rx_ready_i,
  output logic                         frame_err_o,
  output logic                         overflow_o,
  output logic                         rx_busy_o,
  output logic [$clog2(FifoDepth):0]   fifo_level_o
);

  localparam int c_clks_per_bit = clks_per_bit(ClockFrequency, BaudRate);
  localparam int c_cnt_w        = (c_clks_per_bit > 2) ? $clog2(c_clks_per_bit) : 1;

  localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(c_clks_per_bit - 1);
  localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(c_clks_per_bit / 2 - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
  localparam logic [2:0]         c_last_bit  = 3'(UART_DATA_BITS - 1);

  // Synchronizer and edge history
  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic w_start_edge;

  // Frame FSM state and counters
  rx_state_e                 r_state;
  logic [c_cnt_w-1:0]        r_clk_cnt;
  logic [2:0]                r_bit_cnt;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic                      r_push;
  logic                      r_frame_err;
  logic                      r_overflow;

  logic w_fifo_full;
  logic w_pop;

  // A start edge is a falling transition seen after synchronization; a line
  // that stays low after a bad stop bit therefore cannot restart the FSM.
  assign w_start_edge = ~r_sync2 & r_prev;
  assign w_pop        = rx_valid_o & rx_ready_i;

  assign frame_err_o  = r_frame_err;
  assign overflow_o   = r_overflow;
  assign rx_busy_o    = (r_state != IDLE);

  // Two-flop synchronizer plus one history flop, all idling at line-high.
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= uart_rx_i;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Frame FSM: half-bit start qualification, then mid-bit sampling of data
  // and stop; push and error are single-cycle registered pulses.
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      r_state     <= IDLE;
      r_clk_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_push      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_push      <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start_edge) begin
            r_state   <= START;
            r_clk_cnt <= '0;
          end
        end
        START: begin
          if (r_clk_cnt == c_half_last) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            // A line back high at mid-start was a glitch, not a frame.
            r_state   <= r_sync2 ? IDLE : DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + c_cnt_one;
          end
        end
        DATA: begin
          if (r_clk_cnt == c_bit_last) begin
            r_clk_cnt <= '0;
            r_shift   <= {r_sync2, r_shift[UART_DATA_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == c_last_bit) begin
              r_state <= STOP;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + c_cnt_one;
          end
        end
        STOP: begin
          if (r_clk_cnt == c_bit_last) begin
            r_clk_cnt   <= '0;
            r_push      <= r_sync2;
            r_frame_err <= ~r_sync2;
            r_state     <= IDLE;
          end else begin
            r_clk_cnt <= r_clk_cnt + c_cnt_one;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_clk_cnt <= '0;
        end
      endcase
    end
  end

  // Sticky overflow: a push that the full FIFO had to refuse.
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      r_overflow <= 1'b0;
    end else if (r_push && w_fifo_full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  uart_sync_fifo #(
    .Width (UART_DATA_BITS),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk       (clk_sys_i),
    .rst       (rst_sys_i),
    .push      (r_push),
    .push_data (r_shift),
    .full      (w_fifo_full),
    .pop_valid (rx_valid_o),
    .pop_ready (rx_ready_i),
    .pop_data  (rx_data_o),
    .level     (fifo_level_o)
  );

endmodule : uart_rx_sink

`default_nettype wire
